// File: rtl/apb_master_fsm_pkg.sv
// Shared definitions for the AHB2APB bridge: FSM states, slot map, helpers.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam logic [31:0] SLOT0_BASE = 32'h8000_0000;
  localparam logic [31:0] SLOT_SIZE  = 32'h0400_0000;
  localparam int          NUM_SLOTS  = 3;
  localparam logic [2:0]  PSEL_NONE  = 3'b000;

  // Base address of slot idx; idx == NUM_SLOTS gives the end of the map.
  function automatic logic [31:0] slot_base(input int idx);
    return SLOT0_BASE + SLOT_SIZE * 32'(idx);
  endfunction

endpackage

// File: rtl/apb_master_fsm_if.sv
// Command/response and APB bus bundle between bridge front end, FSM and slaves.
interface apb_master_fsm_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              pwrite;
  logic              penable;
  logic [2:0]        psel;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;

  // APB initiator view
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           pwrite, penable, psel, paddr, pwdata
  );

  // Front end plus peripheral view
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           pwrite, penable, psel, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_fsm_addr_decode.sv
// Combinational slot decoder: address -> one-hot select plus hit flag.
module apb_addr_decode
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0]    addr,
  output logic                 hit,
  output logic [NUM_SLOTS-1:0] psel
);

  // Each slot is a half-open window [base, base + SLOT_SIZE).
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      localparam logic [ADDR_W-1:0] LO = ADDR_W'(slot_base(gi));
      localparam logic [ADDR_W-1:0] HI = ADDR_W'(slot_base(gi + 1));
      assign psel[gi] = (addr >= LO) && (addr < HI);
    end
  endgenerate

  assign hit = |psel;

endmodule

// File: rtl/apb_master_fsm.sv
// APB initiator: one command per transfer, SETUP/ACCESS sequencing,
// pready timeout and a one-cycle response pulse.
module apb_master_fsm
  import apb_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic             Hclk,
  input  logic             Hreset,
  apb_master_fsm_if.master bus
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

  apb_state_t        state_reg, state_next;
  logic [2:0]        psel_reg, psel_next;
  logic              penable_reg, penable_next;
  logic              pwrite_reg, pwrite_next;
  logic [ADDR_W-1:0] paddr_reg, paddr_next;
  logic [DATA_W-1:0] pwdata_reg, pwdata_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic              rsp_err_reg, rsp_err_next;
  logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic [7:0]        cnt_reg, cnt_next;
  // A miss accepted alongside a completion owes its error pulse one cycle later.
  logic              pend_miss_reg, pend_miss_next;

  logic              dec_hit;
  logic [2:0]        dec_psel;
  logic              cmd_ready;
  logic              accept;

  apb_addr_decode #(.ADDR_W(ADDR_W)) u_decode (
    .addr (bus.cmd_addr),
    .hit  (dec_hit),
    .psel (dec_psel)
  );

  assign cmd_ready = (state_reg == IDLE) || ((state_reg == ACCESS) && bus.pready);
  assign accept    = bus.cmd_valid && cmd_ready;

  // State and registered outputs
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_reg     <= IDLE;
      psel_reg      <= PSEL_NONE;
      penable_reg   <= 1'b0;
      pwrite_reg    <= 1'b0;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
      cnt_reg       <= '0;
      pend_miss_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      psel_reg      <= psel_next;
      penable_reg   <= penable_next;
      pwrite_reg    <= pwrite_next;
      paddr_reg     <= paddr_next;
      pwdata_reg    <= pwdata_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_rdata_reg <= rsp_rdata_next;
      cnt_reg       <= cnt_next;
      pend_miss_reg <= pend_miss_next;
    end
  end

  // Next-state, bus and response logic
  always_comb begin
    state_next     = state_reg;
    psel_next      = psel_reg;
    penable_next   = penable_reg;
    pwrite_next    = pwrite_reg;
    paddr_next     = paddr_reg;
    pwdata_next    = pwdata_reg;
    rsp_valid_next = 1'b0;
    rsp_err_next   = 1'b0;
    rsp_rdata_next = '0;
    cnt_next       = cnt_reg;
    pend_miss_next = pend_miss_reg;

    unique case (state_reg)
      IDLE: begin
        psel_next      = PSEL_NONE;
        penable_next   = 1'b0;
        pend_miss_next = 1'b0;
        if (pend_miss_reg) begin
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
        end
        if (accept) begin
          if (dec_hit) begin
            paddr_next  = bus.cmd_addr;
            pwrite_next = bus.cmd_write;
            pwdata_next = bus.cmd_wdata;
            psel_next   = dec_psel;
            state_next  = SETUP;
          end else if (pend_miss_reg) begin
            // Response slot is taken by the owed error; push this one out.
            pend_miss_next = 1'b1;
          end else begin
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b1;
          end
        end
      end

      SETUP: begin
        penable_next = 1'b1;
        cnt_next     = '0;
        state_next   = ACCESS;
      end

      ACCESS: begin
        if (bus.pready) begin
          rsp_valid_next = 1'b1;
          rsp_rdata_next = pwrite_reg ? '0 : bus.prdata;
          psel_next      = PSEL_NONE;
          penable_next   = 1'b0;
          state_next     = IDLE;
          if (accept) begin
            if (dec_hit) begin
              paddr_next  = bus.cmd_addr;
              pwrite_next = bus.cmd_write;
              pwdata_next = bus.cmd_wdata;
              psel_next   = dec_psel;
              state_next  = SETUP;
            end else begin
              pend_miss_next = 1'b1;
            end
          end
        end else if (cnt_reg == CNT_LAST) begin
          psel_next      = PSEL_NONE;
          penable_next   = 1'b0;
          state_next     = IDLE;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
        end else if (cnt_reg != 8'hFF) begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      default: begin
        state_next   = IDLE;
        psel_next    = PSEL_NONE;
        penable_next = 1'b0;
      end
    endcase
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.pwrite    = pwrite_reg;
  assign bus.penable   = penable_reg;
  assign bus.psel      = psel_reg;
  assign bus.paddr     = paddr_reg;
  assign bus.pwdata    = pwdata_reg;

endmodule

// File: tb/tb_apb_master_fsm.sv
// Directed bench for apb_master_fsm: single write, waited read, back-to-back,
// decode miss, timeout, miss behind a completion and reset mid-ACCESS.
module tb_apb_master_fsm;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  apb_master_fsm_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_master_fsm #(.TIMEOUT_CYC(16), .ADDR_W(32), .DATA_W(32)) dut (
    .Hclk   (clk),
    .Hreset (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
  endtask

  task automatic drop_cmd();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic e, input logic [31:0] d);
    check_eq({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'(v));
    check_eq({tag, ".rsp_err"},   64'(bus.rsp_err),   64'(e));
    check_eq({tag, ".rsp_rdata"}, 64'(bus.rsp_rdata), 64'(d));
  endtask

  task automatic check_bus(input string tag, input logic [2:0] ps, input logic pe);
    check_eq({tag, ".psel"},    64'(bus.psel),    64'(ps));
    check_eq({tag, ".penable"}, 64'(bus.penable), 64'(pe));
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.prdata    = '0;
    bus.pready    = 1'b1;

    // Reset for two cycles
    tick();
    tick();
    check_bus("reset", 3'b000, 1'b0);
    check_eq("reset.pwrite", 64'(bus.pwrite), 64'd0);
    check_eq("reset.paddr",  64'(bus.paddr),  64'd0);
    check_eq("reset.pwdata", 64'(bus.pwdata), 64'd0);
    check_rsp("reset", 1'b0, 1'b0, 32'h0);
    rst = 1'b0;

    // Single zero-wait write
    check_eq("wr.cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
    drive_cmd(1'b1, 32'h8000_0010, 32'hDEAD_BEEF);
    tick();
    drop_cmd();
    check_bus("wr.setup", 3'b001, 1'b0);
    check_eq("wr.setup.paddr",  64'(bus.paddr),  64'h8000_0010);
    check_eq("wr.setup.pwdata", 64'(bus.pwdata), 64'hDEAD_BEEF);
    check_eq("wr.setup.pwrite", 64'(bus.pwrite), 64'd1);
    check_eq("wr.setup.cmd_ready", 64'(bus.cmd_ready), 64'd0);
    tick();
    check_bus("wr.access", 3'b001, 1'b1);
    check_eq("wr.access.rsp_valid", 64'(bus.rsp_valid), 64'd0);
    tick();
    check_rsp("wr.rsp", 1'b1, 1'b0, 32'h0);
    check_bus("wr.after", 3'b000, 1'b0);
    tick();
    check_eq("wr.rsp_one_cycle", 64'(bus.rsp_valid), 64'd0);

    // Read with three wait states
    bus.pready = 1'b0;
    drive_cmd(1'b0, 32'h8400_0004, 32'h0);
    tick();
    drop_cmd();
    check_bus("rdw.setup", 3'b010, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_bus($sformatf("rdw.wait%0d", i), 3'b010, 1'b1);
      check_eq($sformatf("rdw.wait%0d.paddr", i), 64'(bus.paddr), 64'h8400_0004);
      check_eq($sformatf("rdw.wait%0d.cmd_ready", i), 64'(bus.cmd_ready), 64'd0);
    end
    tick();
    bus.pready = 1'b1;
    bus.prdata = 32'h0000_0042;
    check_bus("rdw.ready", 3'b010, 1'b1);
    tick();
    bus.prdata = 32'h0;
    check_rsp("rdw.rsp", 1'b1, 1'b0, 32'h42);
    tick();

    // Back-to-back: read slot 2 then write slot 0 offered on completion
    drive_cmd(1'b0, 32'h8800_0000, 32'h0);
    tick();
    drop_cmd();
    check_bus("b2b.setup1", 3'b100, 1'b0);
    tick();
    drive_cmd(1'b1, 32'h8000_0000, 32'h0000_1234);
    bus.prdata = 32'h0000_0077;
    check_eq("b2b.cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check_bus("b2b.access1", 3'b100, 1'b1);
    tick();
    drop_cmd();
    bus.prdata = 32'h0;
    check_bus("b2b.setup2", 3'b001, 1'b0);
    check_eq("b2b.setup2.paddr", 64'(bus.paddr), 64'h8000_0000);
    check_rsp("b2b.rsp1", 1'b1, 1'b0, 32'h77);
    tick();
    check_bus("b2b.access2", 3'b001, 1'b1);
    check_eq("b2b.gap", 64'(bus.rsp_valid), 64'd0);
    tick();
    check_rsp("b2b.rsp2", 1'b1, 1'b0, 32'h0);
    tick();

    // Decode miss
    drive_cmd(1'b1, 32'h9000_0000, 32'h5555_5555);
    check_eq("miss.cmd_ready", 64'(bus.cmd_ready), 64'd1);
    tick();
    drop_cmd();
    check_bus("miss", 3'b000, 1'b0);
    check_rsp("miss.rsp", 1'b1, 1'b1, 32'h0);
    tick();
    check_bus("miss.after", 3'b000, 1'b0);
    check_eq("miss.rsp_one_cycle", 64'(bus.rsp_valid), 64'd0);

    // Timeout after 16 ACCESS cycles
    bus.pready = 1'b0;
    bus.prdata = 32'h0000_00AA;
    drive_cmd(1'b0, 32'h8000_0000, 32'h0);
    tick();
    drop_cmd();
    check_bus("to.setup", 3'b001, 1'b0);
    for (int i = 0; i < 16; i++) begin
      tick();
      check_bus($sformatf("to.wait%0d", i), 3'b001, 1'b1);
      check_eq($sformatf("to.wait%0d.rsp_valid", i), 64'(bus.rsp_valid), 64'd0);
    end
    tick();
    check_bus("to.abort", 3'b000, 1'b0);
    check_rsp("to.rsp", 1'b1, 1'b1, 32'h0);
    bus.pready = 1'b1;
    bus.prdata = 32'h0000_0055;
    drive_cmd(1'b0, 32'h8400_0008, 32'h0);
    tick();
    drop_cmd();
    check_bus("to.next.setup", 3'b010, 1'b0);
    tick();
    tick();
    check_rsp("to.next.rsp", 1'b1, 1'b0, 32'h55);
    bus.prdata = 32'h0;
    tick();

    // Miss offered in a completing ACCESS: error one cycle after completion
    bus.prdata = 32'h0000_0031;
    drive_cmd(1'b0, 32'h8000_0020, 32'h0);
    tick();
    drop_cmd();
    tick();
    drive_cmd(1'b1, 32'hA000_0000, 32'h0);
    check_eq("bmiss.cmd_ready", 64'(bus.cmd_ready), 64'd1);
    tick();
    drop_cmd();
    bus.prdata = 32'h0;
    check_rsp("bmiss.rsp1", 1'b1, 1'b0, 32'h31);
    check_bus("bmiss.idle", 3'b000, 1'b0);
    tick();
    check_rsp("bmiss.rsp2", 1'b1, 1'b1, 32'h0);
    tick();
    check_eq("bmiss.quiet", 64'(bus.rsp_valid), 64'd0);

    // Reset during an ACCESS wait state
    bus.pready = 1'b0;
    drive_cmd(1'b1, 32'h8800_0004, 32'hCAFE_F00D);
    tick();
    drop_cmd();
    tick();
    tick();
    check_bus("rstmid.wait", 3'b100, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_bus("rstmid.reset", 3'b000, 1'b0);
    check_eq("rstmid.paddr",  64'(bus.paddr),  64'd0);
    check_eq("rstmid.pwdata", 64'(bus.pwdata), 64'd0);
    check_eq("rstmid.pwrite", 64'(bus.pwrite), 64'd0);
    check_rsp("rstmid.rsp", 1'b0, 1'b0, 32'h0);
    tick();
    check_eq("rstmid.no_rsp", 64'(bus.rsp_valid), 64'd0);
    bus.pready = 1'b1;
    bus.prdata = 32'h0000_0099;
    drive_cmd(1'b0, 32'h8800_0010, 32'h0);
    tick();
    drop_cmd();
    check_bus("rstmid.next.setup", 3'b100, 1'b0);
    tick();
    tick();
    check_rsp("rstmid.next.rsp", 1'b1, 1'b0, 32'h99);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_fsm.md
Name: apb_master_fsm

Overview:
- APB initiator for the AHB2APB bridge: accepts one latched command per transfer from the bridge front end and drives the APB SETUP/ACCESS phases toward the three peripheral slots.
- It is the requesting end of the interface that the slave-side APB interface model responds to.
- Decodes the address into a one-hot psel, waits on pready with a timeout, and returns read data plus an error flag as a one-cycle response pulse.

Parameters:
- TIMEOUT_CYC, 16, ACCESS cycles without pready before the transfer aborts with error (legal range 1..255).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- Hclk  in  1  clock; all logic on rising edge
- Hreset  in  1  synchronous reset, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted this cycle when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  decode miss or timeout
- pwrite  out  1  APB write
- penable  out  1  APB enable
- psel  out  3  APB one-hot slave select
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB ready from selected slave

Behaviour:
- Reset (Hreset high at a clock edge):
  - state = IDLE.
  - psel = 3'b000, penable = 0, pwrite = 0, paddr = 0, pwdata = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, timeout counter = 0.
  - Reset mid-transfer drops psel/penable on the next edge; no response is issued.
- Decode, combinational on cmd_addr:
  - 0x8000_0000..0x83FF_FFFF -> 3'b001
  - 0x8400_0000..0x87FF_FFFF -> 3'b010
  - 0x8800_0000..0x8BFF_FFFF -> 3'b100
  - anything else -> miss
- cmd_ready = (state == IDLE) || (state == ACCESS && pready).
- States:
  - IDLE:
    - Accept with decode hit: register addr, write, wdata; psel = decoded value, penable = 0; go to SETUP.
    - Accept with miss: no APB activity; next cycle rsp_valid = 1, rsp_err = 1, rsp_rdata = 0; stay IDLE.
  - SETUP: exactly one cycle; penable = 1, counter cleared; go to ACCESS.
  - ACCESS:
    - Hold paddr, pwrite, pwdata, psel and penable stable.
    - If pready = 1:
      - Complete the transfer. Next cycle rsp_valid = 1, rsp_err = 0.
      - rsp_rdata = prdata sampled this cycle for reads; 0 for writes.
      - If a new command is accepted in the same cycle: hit goes straight to SETUP (penable = 0, new psel/paddr); miss goes to IDLE and issues its error response one cycle after the completion response.
      - Otherwise go to IDLE with psel = 0 and penable = 0.
    - If pready = 0: increment the counter. When the counter reaches TIMEOUT_CYC - 1 with pready still low, abort: next cycle psel = 0, penable = 0, state IDLE, rsp_valid = 1, rsp_err = 1, rsp_rdata = 0. The counter saturates; it never wraps.
- Latency: zero-wait transfer = accept edge -> SETUP -> ACCESS -> rsp_valid on the following cycle (3 cycles after accept). Back-to-back zero-wait transfers sustain 2 cycles per transfer.
- rsp_valid is high for exactly one cycle per accepted command. There is no response backpressure.
- pwdata is driven for reads too (holds the last registered value). Slaves ignore it.

Decomposition:
- Shared package apb_bridge_pkg:
  - state enum {IDLE, SETUP, ACCESS}
  - slot base/limit constants: SLOT0_BASE = 32'h8000_0000, SLOT_SIZE = 32'h0400_0000
  - PSEL_NONE = 3'b000
- One natural sub-module: apb_addr_decode, combinational, cmd_addr -> {hit, psel[2:0]}. It is reused by the bridge's AHB-side valid check.

Test Plan:
- Single write: Hreset 2 cycles, then write 0x8000_0010 data 0xDEAD_BEEF with pready tied 1 -> psel = 001 in SETUP with penable = 0; penable = 1 next cycle; rsp_valid 3 cycles after accept, rsp_err = 0, rsp_rdata = 0.
- Read with waits: read 0x8400_0004, pready low for 3 ACCESS cycles then high with prdata = 0x0000_0042 -> psel = 010 held stable throughout; rsp_rdata = 0x42, rsp_err = 0.
- Back-to-back: read 0x8800_0000 then write 0x8000_0000 offered in the completing ACCESS cycle -> cmd_ready high that cycle; psel goes 100 -> 001 with no IDLE cycle; two rsp_valid pulses 2 cycles apart.
- Decode miss: write 0x9000_0000 -> psel stays 000 and penable stays 0; one cycle after accept rsp_valid = 1, rsp_err = 1.
- Timeout: read 0x8000_0000 with pready held 0 and TIMEOUT_CYC = 16 -> 16 ACCESS cycles, then psel/penable drop, rsp_err = 1, rsp_rdata = 0; a following command is accepted normally.
- Reset mid-ACCESS: assert Hreset during a wait state -> next edge all outputs at reset values, no rsp_valid; a new command after reset completes correctly.
